uart_frame_arbiter: RTL and testbench

- Shares one byte-wide UART transmitter between N_REQ requesters.
- Each requester submits 32-bit debug frames laid out as {custom_cmd[7:0], cmd[7:0], data[15:0]}.
- The block selects requesters round-robin, serialises each granted frame into 4 bytes (MSB first), and drives the transmitter's data-valid/byte/done handshake.
- It emits an init sync burst after reset and inserts a periodic all-ones SYNC frame so the host-side decoder can realign.

---
 rtl/uart_frame_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_uart_frame_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter between N_REQ
// frame sources, serialising 32-bit frames MSB first with init and periodic SYNC.
module uart_frame_arbiter #(
   parameter int N_REQ           = 4,
   parameter int SYNC_INTERVAL   = 64,
   parameter int INIT_SYNC_BYTES = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [32*N_REQ-1:0]        req_frame,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       tx_dv,
   output logic [7:0]                 tx_byte,
   input  logic                       tx_active,
   input  logic                       tx_done,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy,
   output logic                       frame_sent
);

   localparam int GW = $clog2(N_REQ);
   localparam int CW = (SYNC_INTERVAL > 0) ? $clog2(SYNC_INTERVAL + 1) : 1;
   localparam int IW = (INIT_SYNC_BYTES > 0) ? $clog2(INIT_SYNC_BYTES + 1) : 1;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_SEND,
      S_WAIT_ACT,
      S_WAIT_DONE
   } state_t;

   state_t        state_q;
   logic [31:0]   frame_q;
   logic [1:0]    byte_idx_q;
   logic [GW-1:0] rr_q;
   logic [CW-1:0] frame_cnt_q;
   logic [IW-1:0] init_cnt_q;
   logic          init_phase_q;
   logic          is_sync_q;
   logic          tx_dv_q;
   logic [7:0]    tx_byte_q;
   logic [GW-1:0] grant_q;
   logic          busy_q;
   logic          frame_sent_q;

   logic [31:0]   frames [N_REQ];
   logic [GW:0]   rot_idx_d;
   logic [GW-1:0] pick_d;
   logic [GW-1:0] rr_next_d;
   logic          found_d;
   logic          sync_due_d;
   logic          issue_ok_d;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_frames
         assign frames[gi] = req_frame[32*gi +: 32];
      end
   endgenerate

   // First valid requester at or after the round-robin pointer, wrapping.
   always_comb begin
      found_d   = 1'b0;
      pick_d    = '0;
      rot_idx_d = '0;
      for (int off = 0; off < N_REQ; off++) begin
         rot_idx_d = {1'b0, rr_q} + (GW+1)'(off);
         if (rot_idx_d >= (GW+1)'(N_REQ)) begin
            rot_idx_d = rot_idx_d - (GW+1)'(N_REQ);
         end
         if (!found_d && req_valid[rot_idx_d[GW-1:0]]) begin
            found_d = 1'b1;
            pick_d  = rot_idx_d[GW-1:0];
         end
      end
   end

   assign rr_next_d  = (pick_d == GW'(N_REQ - 1)) ? '0 : pick_d + 1'b1;
   assign sync_due_d = (SYNC_INTERVAL != 0) && (frame_cnt_q == CW'(SYNC_INTERVAL));
   assign issue_ok_d = !tx_active && !tx_done;

   // Accept is combinational so the frame is latched in the same IDLE cycle it is seen.
   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && !sync_due_d && found_d) begin
         req_ready[pick_d] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_INIT;
         frame_q      <= '0;
         byte_idx_q   <= '0;
         rr_q         <= '0;
         frame_cnt_q  <= '0;
         init_cnt_q   <= '0;
         init_phase_q <= 1'b1;
         is_sync_q    <= 1'b0;
         tx_dv_q      <= 1'b0;
         tx_byte_q    <= 8'hFF;
         grant_q      <= '0;
         busy_q       <= 1'b0;
         frame_sent_q <= 1'b0;
      end else begin
         tx_dv_q      <= 1'b0;
         frame_sent_q <= 1'b0;
         case (state_q)
            S_INIT: begin
               if (INIT_SYNC_BYTES == 0) begin
                  init_phase_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end else begin
                  busy_q <= 1'b1;
                  if (issue_ok_d) begin
                     tx_byte_q <= 8'hFF;
                     tx_dv_q   <= 1'b1;
                     state_q   <= S_WAIT_ACT;
                  end
               end
            end
            S_IDLE: begin
               if (sync_due_d) begin
                  frame_q     <= 32'hFFFF_FFFF;
                  is_sync_q   <= 1'b1;
                  frame_cnt_q <= '0;
                  byte_idx_q  <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= S_SEND;
               end else if (found_d) begin
                  frame_q    <= frames[pick_d];
                  is_sync_q  <= 1'b0;
                  grant_q    <= pick_d;
                  rr_q       <= rr_next_d;
                  byte_idx_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= S_SEND;
               end
            end
            S_SEND: begin
               if (issue_ok_d) begin
                  tx_byte_q <= frame_q[31:24];
                  frame_q   <= {frame_q[23:0], 8'h00};
                  tx_dv_q   <= 1'b1;
                  state_q   <= S_WAIT_ACT;
               end
            end
            S_WAIT_ACT: begin
               if (tx_active) begin
                  state_q <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (tx_done && !tx_active) begin
                  if (init_phase_q) begin
                     init_cnt_q <= init_cnt_q + 1'b1;
                     if (init_cnt_q == IW'(INIT_SYNC_BYTES - 1)) begin
                        init_phase_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                     end else begin
                        state_q <= S_INIT;
                     end
                  end else if (byte_idx_q == 2'd3) begin
                     frame_sent_q <= 1'b1;
                     byte_idx_q   <= '0;
                     busy_q       <= 1'b0;
                     state_q      <= S_IDLE;
                     if (!is_sync_q && frame_cnt_q != CW'(SYNC_INTERVAL)) begin
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                     end
                  end else begin
                     byte_idx_q <= byte_idx_q + 1'b1;
                     state_q    <= S_SEND;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx_dv      = tx_dv_q;
   assign tx_byte    = tx_byte_q;
   assign grant_id   = grant_q;
   assign busy       = busy_q;
   assign frame_sent = frame_sent_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Randomised bench for uart_frame_arbiter: a transmitter model plus a queue-based
// reference of the expected byte stream, grant order and SYNC insertion.
module tb_uart_frame_arbiter;

   localparam int N    = 4;
   localparam int SI   = 3;
   localparam int INIT = 12;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [32*N-1:0] req_frame = '0;
   logic [N-1:0]   req_ready;
   logic           tx_dv;
   logic [7:0]     tx_byte;
   logic           tx_active = 1'b0;
   logic           tx_done = 1'b0;
   logic [1:0]     grant_id;
   logic           busy;
   logic           frame_sent;

   uart_frame_arbiter #(
      .N_REQ(N), .SYNC_INTERVAL(SI), .INIT_SYNC_BYTES(INIT)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_frame(req_frame),
      .req_ready(req_ready), .tx_dv(tx_dv), .tx_byte(tx_byte),
      .tx_active(tx_active), .tx_done(tx_done), .grant_id(grant_id),
      .busy(busy), .frame_sent(frame_sent)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] rq [N][$];
   logic [7:0]  exp_q [$];
   int          m_rr, m_cnt, init_left, bytes_since_fs, frame_bytes;
   int          done_len = 1;
   int          act_cnt, done_cnt, pend_g;
   logic        start_pend = 1'b0;
   logic        pend_chk;
   logic [N-1:0] pop_mask;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      for (int k = 0; k < INIT; k++) exp_q.push_back(8'hFF);
      m_rr = 0; m_cnt = 0; init_left = INIT;
      bytes_since_fs = 0; frame_bytes = 0;
      pop_mask = '0; pend_chk = 1'b0;
   endtask

   task automatic push_bytes(input logic [31:0] f);
      for (int k = 0; k < 4; k++) exp_q.push_back(8'(f >> (24 - 8*k)));
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: observe at negedge, update transmitter model, drive requests after posedge.
   task automatic tick();
      logic         dv, fs;
      logic [7:0]   b;
      logic [N-1:0] rdy;
      @(negedge clk);
      dv = tx_dv; b = tx_byte; rdy = req_ready; fs = frame_sent;
      if (!rst) begin
         if (dv) begin
            check("tx_idle_at_dv", 32'({start_pend, tx_active, tx_done}), 0);
            check("byte_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("tx_byte", b, exp_q.pop_front());
            if (init_left > 0) init_left--;
            else begin bytes_since_fs++; frame_bytes++; end
         end
         if (fs) begin
            check("frame_sent_bytes", bytes_since_fs, 4);
            bytes_since_fs = 0;
         end
         if (rdy != '0) begin
            int g = -1;
            logic [N-1:0] ev = '0;
            for (int off = 0; off < N; off++) begin
               int idx = (m_rr + off) % N;
               if (g < 0 && req_valid[idx]) g = idx;
            end
            if (g >= 0) ev[g] = 1'b1;
            check("req_ready", rdy, ev);
            if (g >= 0) begin
               push_bytes(rq[g][0]);
               m_rr = (g + 1) % N;
               m_cnt++;
               if (m_cnt == SI) begin
                  push_bytes(32'hFFFF_FFFF);
                  m_cnt = 0;
               end
               pop_mask[g] = 1'b1;
               pend_g = g; pend_chk = 1'b1; frame_bytes = 0;
            end
         end
      end
      if (tx_active) begin
         act_cnt--;
         if (act_cnt == 0) begin tx_active = 1'b0; tx_done = 1'b1; done_cnt = done_len; end
      end else if (tx_done) begin
         done_cnt--;
         if (done_cnt == 0) tx_done = 1'b0;
      end else if (start_pend) begin
         start_pend = 1'b0; tx_active = 1'b1; act_cnt = $urandom_range(1, 4);
      end
      if (dv && !rst) start_pend = 1'b1;
      @(posedge clk);
      #1;
      if (pend_chk) begin
         check("grant_id", grant_id, pend_g);
         pend_chk = 1'b0;
      end
      for (int i = 0; i < N; i++) if (pop_mask[i]) void'(rq[i].pop_front());
      pop_mask = '0;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = (rq[i].size() != 0);
         req_frame[32*i +: 32] = req_valid[i] ? rq[i][0] : $urandom();
      end
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (exp_q.size() == 0 && !busy && !tx_active && !tx_done && !start_pend &&
             req_valid == '0 && all_empty()) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_reached", 32'(ok), 1);
      repeat (20) tick();
      check("busy_idle", 32'(busy), 0);
      check("exp_left", exp_q.size(), 0);
      check("frame_sent_missing", bytes_since_fs, 0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_tx_dv"}, 32'(tx_dv), 0);
      check({pfx, "_tx_byte"}, tx_byte, 8'hFF);
      check({pfx, "_grant_id"}, grant_id, 0);
      check({pfx, "_busy"}, 32'(busy), 0);
      check({pfx, "_frame_sent"}, 32'(frame_sent), 0);
      check({pfx, "_req_ready"}, req_ready, 0);
   endtask

   initial begin
      bit hit;
      model_reset();
      repeat (3) tick();
      check_reset_outputs("rst");
      rst = 1'b0;
      repeat (3) tick();
      check("init_busy", 32'(busy), 1);
      wait_idle(3000);
      check("init_bytes_left", init_left, 0);

      rq[2].push_back(32'hA1B2_C3D4);
      wait_idle(2000);
      check("single_grant", grant_id, 2);

      for (int i = 0; i < N; i++)
         for (int k = 0; k < 3; k++) rq[i].push_back($urandom());
      wait_idle(8000);

      done_len = 2;
      for (int c = 0; c < 300; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            int g = $urandom_range(0, N - 1);
            rq[g].push_back(($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom());
         end
         tick();
      end
      wait_idle(20000);

      done_len = 1;
      repeat (5) rq[1].push_back($urandom());
      wait_idle(5000);

      rq[0].push_back($urandom()); rq[0].push_back($urandom());
      rq[3].push_back($urandom()); rq[3].push_back($urandom());
      hit = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         tick();
         if (init_left == 0 && frame_bytes == 2 && tx_active) begin
            hit = 1'b1;
            break;
         end
      end
      check("abort_point", 32'(hit), 1);
      #1 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      model_reset();
      tick(); tick();
      rst = 1'b0;
      wait_idle(8000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
